mxu_tile_sequencer: RTL and testbench
=====================================

Name: mxu_tile_sequencer

Overview:
- Parametrised control and datapath front-end for the NxN systolic matrix unit (mxu).
- Accepts a matmul command C = A x B with word addresses into a single-port-per-direction scratch memory.
- Loads A and B, generates the skewed north/west operand streams for any GRID_SIZE, drains results, and optionally applies ReLU on writeback.
- Replaces the hard-coded 2x2 staging and provides a start/done handshake for the instruction sequencer.

Parameters:
- NUM_SIZE, 16, bits per matrix element (signed two's complement).
- GRID_SIZE, 2, N; array is NxN, matrices are NxN.
- ADDR_W, 5, memory word-address width; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on a clk edge with cmd_valid&&cmd_ready.
- cmd_a_addr  in  ADDR_W  base of A, row-major.
- cmd_b_addr  in  ADDR_W  base of B, row-major.
- cmd_c_addr  in  ADDR_W  base of C, row-major.
- cmd_relu  in  1  1 = clamp negative results to 0 on writeback.
- done  out  1  one-cycle pulse when the last C word has been written.
- mem_rd_en  out  1  read strobe.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  NUM_SIZE  data valid exactly one cycle after mem_rd_en.
- mem_wr_en  out  1  write strobe.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  NUM_SIZE  write data.
- mxu_ce  out  1  systolic array clock enable.
- mxu_clr  out  1  one-cycle accumulator clear pulse to the mxu.
- north_input  out  NUM_SIZE*N  column j in slice j.
- west_input  out  NUM_SIZE*N  row i in slice i.
- result_out  in  NUM_SIZE*N*N  element [i][j] in slice k=i*N+j.

Behaviour:
- Reset (any time, including mid-operation): state IDLE, all counters 0, internal A/B arrays 0. cmd_ready=1. done, mem_rd_en, mem_wr_en, mxu_ce and mxu_clr are 0. All address, data and operand outputs are 0. No memory write may occur after rst rises.
- Command capture: all cmd_* fields are latched on the accept edge. Inputs are ignored while busy.
- IDLE -> LOAD on accept.
- LOAD, 2N² cycles:
  - cycle n (0-based) issues a read at a_addr+n for n<N², else at b_addr+(n-N²).
  - data returned the following cycle is stored to A[n/N][n%N] or B[..][..] respectively.
- CLR, 1 cycle:
  - captures the final B word.
  - mxu_clr=1, mxu_ce=0.
- FEED, 3N-2 cycles, with mxu_ce=1 and counter t=0..3N-3:
  - west slice i = A[i][t-i] if 0<=t-i<N, else 0.
  - north slice j = B[t-j][j] if 0<=t-j<N, else 0.
  - these are combinational from the state registers.
- STORE, N² cycles:
  - mxu_ce=0; the mxu holds its accumulators.
  - cycle m writes mem_wr_addr=c_addr+m and mem_wr_data=result[m/N][m%N].
  - if relu is latched and the value is negative, the write data is 0 instead.
- DONE, 1 cycle: done=1, then IDLE. cmd_ready returns to 1 in the cycle after the done pulse.
- Latency: done is asserted in cycle 3N²+3N after the accept edge (N=2: 18; N=4: 60).
- Read/write ordering: reads and writes never overlap. Writes may overwrite A/B source words (in-place is legal).
- Address wrap: a base near the top of memory wraps to 0 with no error.
- No accept is possible while busy; a held cmd_valid is accepted on the edge where cmd_ready is next 1.

Test Plan:
- N=2, A=[1,2,3,4] @0, B=identity @4, C @8, relu=0 -> mem[8..11]=1,2,3,4; done in cycle 18; exactly 4 writes.
- N=2, A=[1,-2,3,4], B=[[1,2],[0,1]], relu=1 -> computed [1,0,3,10], written [1,0,3,10]. With relu=0, A=[1,-2,-3,4], same B -> [1,0,-3,-2] raw (0xFFFD, 0xFFFE).
- Address wrap, ADDR_W=5: a_addr=30 -> reads at 30,31,0,1. c_addr=31 -> writes at 31,0,1,2 with correct values.
- Back-to-back: cmd_valid held high for two commands -> cmd_ready low from accept until after done. Second accept one cycle after the done pulse; second done 19 cycles after the first.
- Reset asserted during FEED (t=2) -> mxu_ce, mem_wr_en and done drop immediately; no writes occur. After release, cmd_ready=1 and a new command completes correctly.
- GRID_SIZE=3, A=B=identity -> C=identity. mxu_ce high for exactly 7 cycles; done in cycle 36.

Source files
------------

// File: rtl/mxu_tile_sequencer.sv
// Command sequencer for the NxN systolic matrix unit: loads A and B from scratch memory,
// streams skewed operands into the array, then writes back C with optional ReLU.
module mxu_tile_sequencer #(
    parameter int unsigned NUM_SIZE  = 16,
    parameter int unsigned GRID_SIZE = 2,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [ADDR_W-1:0]                     cmd_a_addr,
    input  logic [ADDR_W-1:0]                     cmd_b_addr,
    input  logic [ADDR_W-1:0]                     cmd_c_addr,
    input  logic                                  cmd_relu,
    output logic                                  done,
    output logic                                  mem_rd_en,
    output logic [ADDR_W-1:0]                     mem_rd_addr,
    input  logic [NUM_SIZE-1:0]                   mem_rd_data,
    output logic                                  mem_wr_en,
    output logic [ADDR_W-1:0]                     mem_wr_addr,
    output logic [NUM_SIZE-1:0]                   mem_wr_data,
    output logic                                  mxu_ce,
    output logic                                  mxu_clr,
    output logic [NUM_SIZE*GRID_SIZE-1:0]         north_input,
    output logic [NUM_SIZE*GRID_SIZE-1:0]         west_input,
    input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] result_out
);

    localparam int unsigned NumElems   = GRID_SIZE * GRID_SIZE;
    localparam int unsigned LoadCycles = 2 * NumElems;
    localparam int unsigned FeedCycles = 3 * GRID_SIZE - 2;
    localparam int unsigned CntW       = $clog2(LoadCycles + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StClr,
        StFeed,
        StStore,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   a_addr_q, b_addr_q, c_addr_q;
    logic                relu_q;
    logic [NUM_SIZE-1:0] a_q [GRID_SIZE][GRID_SIZE];
    logic [NUM_SIZE-1:0] b_q [GRID_SIZE][GRID_SIZE];

    logic                ld_en;
    logic [CntW-1:0]     ld_idx;
    logic [NUM_SIZE-1:0] res_word;

    // State and phase counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter restarts at 0 on every phase change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (cmd_valid) state_d = StLoad;
            end
            StLoad: begin
                if (cnt_q == CntW'(LoadCycles - 1)) begin
                    state_d = StClr;
                    cnt_d   = '0;
                end
            end
            StClr: begin
                state_d = StFeed;
                cnt_d   = '0;
            end
            StFeed: begin
                if (cnt_q == CntW'(FeedCycles - 1)) begin
                    state_d = StStore;
                    cnt_d   = '0;
                end
            end
            StStore: begin
                if (cnt_q == CntW'(NumElems - 1)) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Read data lags its request by one cycle; CLR picks up the final B word
    always_comb begin
        ld_en  = 1'b0;
        ld_idx = cnt_q - CntW'(1);
        if (state_q == StLoad && cnt_q != '0) begin
            ld_en = 1'b1;
        end else if (state_q == StClr) begin
            ld_en  = 1'b1;
            ld_idx = CntW'(LoadCycles - 1);
        end
    end

    // Command latch and operand array capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
            relu_q   <= 1'b0;
            for (int unsigned r = 0; r < GRID_SIZE; r++) begin
                for (int unsigned c = 0; c < GRID_SIZE; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else begin
            if (state_q == StIdle && cmd_valid) begin
                a_addr_q <= cmd_a_addr;
                b_addr_q <= cmd_b_addr;
                c_addr_q <= cmd_c_addr;
                relu_q   <= cmd_relu;
            end
            if (ld_en) begin
                for (int unsigned r = 0; r < GRID_SIZE; r++) begin
                    for (int unsigned c = 0; c < GRID_SIZE; c++) begin
                        if (ld_idx == CntW'(r * GRID_SIZE + c)) a_q[r][c] <= mem_rd_data;
                        if (ld_idx == CntW'(NumElems + r * GRID_SIZE + c)) begin
                            b_q[r][c] <= mem_rd_data;
                        end
                    end
                end
            end
        end
    end

    // Outputs decoded from state; operand skew selects element k where t = lane + k
    always_comb begin
        cmd_ready   = (state_q == StIdle);
        done        = (state_q == StDone);
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mxu_ce      = (state_q == StFeed);
        mxu_clr     = (state_q == StClr);
        north_input = '0;
        west_input  = '0;
        res_word    = '0;

        if (state_q == StLoad) begin
            mem_rd_en = 1'b1;
            if (cnt_q < CntW'(NumElems)) begin
                mem_rd_addr = a_addr_q + ADDR_W'(cnt_q);
            end else begin
                mem_rd_addr = b_addr_q + ADDR_W'(cnt_q - CntW'(NumElems));
            end
        end

        if (state_q == StFeed) begin
            for (int unsigned i = 0; i < GRID_SIZE; i++) begin
                for (int unsigned k = 0; k < GRID_SIZE; k++) begin
                    if (cnt_q == CntW'(i + k)) begin
                        west_input[i*NUM_SIZE +: NUM_SIZE]  = a_q[i][k];
                        north_input[i*NUM_SIZE +: NUM_SIZE] = b_q[k][i];
                    end
                end
            end
        end

        if (state_q == StStore) begin
            for (int unsigned m = 0; m < NumElems; m++) begin
                if (cnt_q == CntW'(m)) res_word = result_out[m*NUM_SIZE +: NUM_SIZE];
            end
            mem_wr_en   = 1'b1;
            mem_wr_addr = c_addr_q + ADDR_W'(cnt_q);
            mem_wr_data = (relu_q && res_word[NUM_SIZE-1]) ? '0 : res_word;
        end
    end

endmodule

// File: tb/tb_mxu_tile_sequencer.sv
// Directed bench for mxu_tile_sequencer with a behavioural memory and systolic array.
`timescale 1ns/1ps
module tb_mxu_tile_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- N=2 instance ----------------
    logic        cmd_valid, cmd_ready, cmd_relu, done, rd_en, wr_en, ce, clr;
    logic [4:0]  cmd_a, cmd_b, cmd_c, rd_addr, wr_addr;
    logic [15:0] rd_data, wr_data;
    logic [31:0] north, west;
    logic [63:0] result;

    mxu_tile_sequencer #(.NUM_SIZE(16), .GRID_SIZE(2), .ADDR_W(5)) u_dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a_addr(cmd_a), .cmd_b_addr(cmd_b), .cmd_c_addr(cmd_c), .cmd_relu(cmd_relu),
        .done(done), .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data),
        .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data),
        .mxu_ce(ce), .mxu_clr(clr), .north_input(north), .west_input(west),
        .result_out(result)
    );

    logic [15:0] mem2 [32];
    logic [4:0]  wa2 [64];
    logic [15:0] wd2 [64];
    logic [4:0]  ra2 [128];
    int          wcnt2 = 0;
    int          rcnt2 = 0;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data            <= mem2[rd_addr];
            ra2[rcnt2[6:0]]    <= rd_addr;
            rcnt2              <= rcnt2 + 1;
        end
        if (wr_en) begin
            wa2[wcnt2[5:0]] <= wr_addr;
            wd2[wcnt2[5:0]] <= wr_data;
            wcnt2           <= wcnt2 + 1;
        end
    end

    logic [15:0] a2 [2][2], b2 [2][2], acc2 [2][2], ain2 [2][2], bin2 [2][2];
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ain2[i][0] = west[i*16 +: 16];
            bin2[0][i] = north[i*16 +: 16];
            for (int j = 1; j < 2; j++) begin
                ain2[i][j] = a2[i][j-1];
                bin2[j][i] = b2[j-1][i];
            end
        end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) result[(i*2+j)*16 +: 16] = acc2[i][j];
    end
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (clr) begin
                    a2[i][j] <= '0; b2[i][j] <= '0; acc2[i][j] <= '0;
                end else if (ce) begin
                    a2[i][j]   <= ain2[i][j];
                    b2[i][j]   <= bin2[i][j];
                    acc2[i][j] <= acc2[i][j] + ain2[i][j] * bin2[i][j];
                end
            end
        end
    end

    // ---------------- N=3 instance ----------------
    logic        cmd_valid3, cmd_ready3, cmd_relu3, done3, rd_en3, wr_en3, ce3, clr3;
    logic [4:0]  cmd_a3, cmd_b3, cmd_c3, rd_addr3, wr_addr3;
    logic [15:0] rd_data3, wr_data3;
    logic [47:0] north3, west3;
    logic [143:0] result3;

    mxu_tile_sequencer #(.NUM_SIZE(16), .GRID_SIZE(3), .ADDR_W(5)) u_dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a_addr(cmd_a3), .cmd_b_addr(cmd_b3), .cmd_c_addr(cmd_c3), .cmd_relu(cmd_relu3),
        .done(done3), .mem_rd_en(rd_en3), .mem_rd_addr(rd_addr3), .mem_rd_data(rd_data3),
        .mem_wr_en(wr_en3), .mem_wr_addr(wr_addr3), .mem_wr_data(wr_data3),
        .mxu_ce(ce3), .mxu_clr(clr3), .north_input(north3), .west_input(west3),
        .result_out(result3)
    );

    logic [15:0] mem3 [32];
    logic [4:0]  wa3 [64];
    logic [15:0] wd3 [64];
    int          wcnt3 = 0;

    always @(posedge clk) begin
        if (rd_en3) rd_data3 <= mem3[rd_addr3];
        if (wr_en3) begin
            wa3[wcnt3[5:0]] <= wr_addr3;
            wd3[wcnt3[5:0]] <= wr_data3;
            wcnt3           <= wcnt3 + 1;
        end
    end

    logic [15:0] a3 [3][3], b3 [3][3], acc3 [3][3], ain3 [3][3], bin3 [3][3];
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ain3[i][0] = west3[i*16 +: 16];
            bin3[0][i] = north3[i*16 +: 16];
            for (int j = 1; j < 3; j++) begin
                ain3[i][j] = a3[i][j-1];
                bin3[j][i] = b3[j-1][i];
            end
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) result3[(i*3+j)*16 +: 16] = acc3[i][j];
    end
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (clr3) begin
                    a3[i][j] <= '0; b3[i][j] <= '0; acc3[i][j] <= '0;
                end else if (ce3) begin
                    a3[i][j]   <= ain3[i][j];
                    b3[i][j]   <= bin3[i][j];
                    acc3[i][j] <= acc3[i][j] + ain3[i][j] * bin3[i][j];
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load2(input int base, input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [15:0] v3);
        mem2[(base + 0) % 32] = v0;
        mem2[(base + 1) % 32] = v1;
        mem2[(base + 2) % 32] = v2;
        mem2[(base + 3) % 32] = v3;
    endtask

    // Issue one command on the N=2 instance; returns the cycle in which done was seen
    task automatic run2(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                        input logic relu, output int cyc);
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_c = c; cmd_relu = relu; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
        checks++; if ({done, rd_en, wr_en, ce, clr} !== 5'b0) begin
            errors++; $display("FAIL rst_strobes got %b exp 00000", {done, rd_en, wr_en, ce, clr});
        end
        checks++; if ({rd_addr, wr_addr, wr_data} !== 26'h0) begin
            errors++; $display("FAIL rst_addr_data got %h exp 0", {rd_addr, wr_addr, wr_data});
        end
        checks++; if ({north, west} !== 64'h0) begin
            errors++; $display("FAIL rst_operands got %h exp 0", {north, west});
        end
        checks++; if (cmd_ready3 !== 1'b1 || ce3 !== 1'b0) begin
            errors++; $display("FAIL rst_n3 got ready=%b ce=%b exp 1 0", cmd_ready3, ce3);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int cyc, w0;
        logic [15:0] exp_d [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        load2(0, 16'd1, 16'd2, 16'd3, 16'd4);
        load2(4, 16'd1, 16'd0, 16'd0, 16'd1);
        w0 = wcnt2;
        run2(5'd0, 5'd4, 5'd8, 1'b0, cyc);
        checks++; if (cyc !== 18) begin errors++; $display("FAIL ident_latency got %0d exp 18", cyc); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL ident_after_done got done=%b ready=%b exp 0 1", done, cmd_ready);
        end
        checks++; if (wcnt2 - w0 !== 4) begin errors++; $display("FAIL ident_wcount got %0d exp 4", wcnt2 - w0); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wa2[w0+k] !== 5'(8 + k) || wd2[w0+k] !== exp_d[k]) begin
                errors++;
                $display("FAIL ident_wr%0d got @%0d=%h exp @%0d=%h", k, wa2[w0+k], wd2[w0+k], 8 + k, exp_d[k]);
            end
        end
    endtask

    task automatic test_relu();
        int cyc, w0;
        logic [15:0] e1 [4] = '{16'd1, 16'd0, 16'd3, 16'd10};
        logic [15:0] e2 [4] = '{16'd1, 16'd0, 16'd0, 16'd0};
        logic [15:0] e3 [4] = '{16'd1, 16'd0, 16'hFFFD, 16'hFFFE};
        load2(4, 16'd1, 16'd2, 16'd0, 16'd1);
        // relu on, non-negative result
        load2(0, 16'd1, 16'hFFFE, 16'd3, 16'd4);
        w0 = wcnt2;
        run2(5'd0, 5'd4, 5'd12, 1'b1, cyc);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wa2[w0+k] !== 5'(12 + k) || wd2[w0+k] !== e1[k]) begin
                errors++;
                $display("FAIL relu1_wr%0d got @%0d=%h exp @%0d=%h", k, wa2[w0+k], wd2[w0+k], 12 + k, e1[k]);
            end
        end
        // relu on, negative entries clamp
        load2(0, 16'd1, 16'hFFFE, 16'hFFFD, 16'd4);
        w0 = wcnt2;
        run2(5'd0, 5'd4, 5'd12, 1'b1, cyc);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wd2[w0+k] !== e2[k]) begin
                errors++; $display("FAIL relu2_wr%0d got %h exp %h", k, wd2[w0+k], e2[k]);
            end
        end
        // relu off, raw negatives
        w0 = wcnt2;
        run2(5'd0, 5'd4, 5'd12, 1'b0, cyc);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wd2[w0+k] !== e3[k]) begin
                errors++; $display("FAIL raw_wr%0d got %h exp %h", k, wd2[w0+k], e3[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int cyc, w0, r0;
        logic [4:0]  ra_e [8] = '{5'd30, 5'd31, 5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7};
        logic [4:0]  wa_e [4] = '{5'd31, 5'd0, 5'd1, 5'd2};
        logic [15:0] wd_e [4] = '{16'd5, 16'd6, 16'd7, 16'd8};
        load2(30, 16'd5, 16'd6, 16'd7, 16'd8);
        load2(4, 16'd1, 16'd0, 16'd0, 16'd1);
        w0 = wcnt2; r0 = rcnt2;
        run2(5'd30, 5'd4, 5'd31, 1'b0, cyc);
        @(negedge clk);
        checks++; if (rcnt2 - r0 !== 8) begin errors++; $display("FAIL wrap_rcount got %0d exp 8", rcnt2 - r0); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (ra2[(r0+k) % 128] !== ra_e[k]) begin
                errors++; $display("FAIL wrap_rd%0d got %0d exp %0d", k, ra2[(r0+k) % 128], ra_e[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wa2[w0+k] !== wa_e[k] || wd2[w0+k] !== wd_e[k]) begin
                errors++;
                $display("FAIL wrap_wr%0d got @%0d=%h exp @%0d=%h", k, wa2[w0+k], wd2[w0+k], wa_e[k], wd_e[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, d1, d2, busy_err, w0;
        logic rdy_gap;
        load2(0, 16'd1, 16'd2, 16'd3, 16'd4);
        load2(4, 16'd1, 16'd0, 16'd0, 16'd1);
        w0 = wcnt2;
        @(negedge clk);
        cmd_a = 5'd0; cmd_b = 5'd4; cmd_c = 5'd8; cmd_relu = 1'b0; cmd_valid = 1'b1;
        cyc = 0; d1 = 0; d2 = 0; busy_err = 0; rdy_gap = 1'b0;
        while (d2 == 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (d1 == 0) d1 = cyc;
                else d2 = cyc;
            end
            if (d1 != 0 && cyc == d1 + 1) rdy_gap = cmd_ready;
            else if (cmd_ready) busy_err++;
            if (d1 != 0 && cyc == d1 + 2) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (d1 !== 18) begin errors++; $display("FAIL b2b_first_done got %0d exp 18", d1); end
        checks++; if (d2 - d1 !== 19) begin errors++; $display("FAIL b2b_gap got %0d exp 19", d2 - d1); end
        checks++; if (busy_err !== 0) begin errors++; $display("FAIL b2b_ready_busy got %0d exp 0", busy_err); end
        checks++; if (rdy_gap !== 1'b1) begin errors++; $display("FAIL b2b_ready_gap got %b exp 1", rdy_gap); end
        checks++; if (wcnt2 - w0 !== 8) begin errors++; $display("FAIL b2b_wcount got %0d exp 8", wcnt2 - w0); end
        checks++; if (wd2[w0+7] !== 16'd4 || wa2[w0+7] !== 5'd11) begin
            errors++; $display("FAIL b2b_last_wr got @%0d=%h exp @11=0004", wa2[w0+7], wd2[w0+7]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, w0;
        logic [15:0] e [4] = '{16'd2, 16'd3, 16'd4, 16'd5};
        load2(0, 16'd2, 16'd3, 16'd4, 16'd5);
        load2(4, 16'd1, 16'd0, 16'd0, 16'd1);
        @(negedge clk);
        cmd_a = 5'd0; cmd_b = 5'd4; cmd_c = 5'd16; cmd_relu = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        // LOAD 1..8, CLR 9, FEED t=2 lands in cycle 12
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (ce !== 1'b1) begin errors++; $display("FAIL rstmid_in_feed got ce=%b exp 1", ce); end
        w0 = wcnt2;
        rst = 1'b1;
        #1;
        checks++; if ({ce, wr_en, done} !== 3'b000) begin
            errors++; $display("FAIL rstmid_drop got %b exp 000", {ce, wr_en, done});
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", cmd_ready); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (wcnt2 !== w0) begin errors++; $display("FAIL rstmid_no_writes got %0d exp 0", wcnt2 - w0); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle got %b exp 1", cmd_ready); end
        run2(5'd0, 5'd4, 5'd16, 1'b0, cyc);
        @(negedge clk);
        checks++; if (cyc !== 18) begin errors++; $display("FAIL rstmid_latency got %0d exp 18", cyc); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wa2[w0+k] !== 5'(16 + k) || wd2[w0+k] !== e[k]) begin
                errors++;
                $display("FAIL rstmid_wr%0d got @%0d=%h exp @%0d=%h", k, wa2[w0+k], wd2[w0+k], 16 + k, e[k]);
            end
        end
    endtask

    task automatic test_grid3();
        int cyc, ce_cnt, w0;
        for (int k = 0; k < 9; k++) begin
            mem3[k]     = (k % 4 == 0) ? 16'd1 : 16'd0;
            mem3[9 + k] = (k % 4 == 0) ? 16'd1 : 16'd0;
        end
        w0 = wcnt3;
        @(negedge clk);
        cmd_a3 = 5'd0; cmd_b3 = 5'd9; cmd_c3 = 5'd20; cmd_relu3 = 1'b0; cmd_valid3 = 1'b1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        cyc = 1; ce_cnt = 0;
        while (!done3 && cyc < 200) begin
            if (ce3) ce_cnt++;
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        checks++; if (cyc !== 36) begin errors++; $display("FAIL g3_latency got %0d exp 36", cyc); end
        checks++; if (ce_cnt !== 7) begin errors++; $display("FAIL g3_ce_cycles got %0d exp 7", ce_cnt); end
        checks++; if (wcnt3 - w0 !== 9) begin errors++; $display("FAIL g3_wcount got %0d exp 9", wcnt3 - w0); end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (wa3[w0+k] !== 5'(20 + k) || wd3[w0+k] !== ((k % 4 == 0) ? 16'd1 : 16'd0)) begin
                errors++;
                $display("FAIL g3_wr%0d got @%0d=%h exp @%0d=%0d", k, wa3[w0+k], wd3[w0+k], 20 + k,
                         (k % 4 == 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_relu = 1'b0;
        cmd_valid3 = 1'b0; cmd_a3 = '0; cmd_b3 = '0; cmd_c3 = '0; cmd_relu3 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            mem2[k] = '0;
            mem3[k] = '0;
        end
        test_reset();
        test_identity();
        test_relu();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_grid3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
